// File: rtl/d_window_averager.sv
`default_nettype none
// ============================================================================
//  Module   : d_window_averager
//  Purpose  : Rounded mean of fixed-length windows of N = 2^LOG2_N unsigned
//             D samples (offset samples from the upstream 2-z^-1 stage).
//             A window opens on start in IDLE, takes N d_valid-qualified
//             samples, then spends one DONE cycle. avg/avg_valid show the
//             result after the edge that closes DONE. In continuous mode,
//             a sample arriving during DONE opens the next window, so a
//             gap-free strobe stream loses nothing at window boundaries.
//  Option   : define AVG_PEAK_EN to add a running window-maximum that is
//             published on peak together with avg; otherwise peak is 0.
//  Ports    : carry     - clock, rising edge
//             rst       - asynchronous active-low reset
//             D         - unsigned sample, DW bits
//             d_valid   - one-cycle strobe qualifying D
//             start     - opens a window (honoured in IDLE only)
//             cont      - back-to-back windows, sampled in DONE
//             avg       - registered rounded mean, held between windows
//             avg_valid - one-cycle pulse when avg updates
//             busy      - high whenever the FSM is not IDLE
//             cnt       - samples accumulated in the current window
//             peak      - window maximum (0 without AVG_PEAK_EN)
//  Revision : 1.0 - initial release
// ============================================================================
module d_window_averager #(
  parameter int LOG2_N = 3,   // window length N = 2^LOG2_N, legal 1..6
  parameter int DW     = 5    // sample width
) (
  input  logic              carry,
  input  logic              rst,
  input  logic [DW-1:0]     D,
  input  logic              d_valid,
  input  logic              start,
  input  logic              cont,
  output logic [DW-1:0]     avg,
  output logic              avg_valid,
  output logic              busy,
  output logic [LOG2_N:0]   cnt,
  output logic [DW-1:0]     peak
);

  // One spare bit above DW+LOG2_N keeps the rounding add overflow-free too.
  localparam int                c_acc_w = DW + LOG2_N + 1;
  localparam int                c_n     = 1 << LOG2_N;
  localparam logic [c_acc_w-1:0] c_half = c_acc_w'(c_n / 2);
  localparam logic [LOG2_N:0]   c_last  = (LOG2_N + 1)'(c_n - 1);
  localparam logic [LOG2_N:0]   c_one   = (LOG2_N + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_acc_w-1:0]   r_acc;
  logic [LOG2_N:0]      r_cnt;
  logic [DW-1:0]        r_avg;
  logic                 r_avg_valid;

  logic [c_acc_w-1:0]   w_d_ext;
  logic [c_acc_w-1:0]   w_sum;
  logic [c_acc_w-1:0]   w_rounded;
  logic [DW-1:0]        w_avg;
  logic                 w_unused;

  assign w_d_ext   = {{(c_acc_w - DW){1'b0}}, D};
  assign w_sum     = r_acc + w_d_ext;
  // Round half up. With a full window acc <= N*(2^DW-1), so the shifted
  // result always fits in DW bits and the dropped top bit is zero.
  assign w_rounded = r_acc + c_half;
  assign w_avg     = w_rounded[LOG2_N +: DW];
  assign w_unused  = ^{w_rounded[LOG2_N-1:0], w_rounded[c_acc_w-1]};

  always_ff @(posedge carry or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // d_valid is deliberately ignored until a window is opened.
          if (start) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ACCUM: begin
          // start is not looked at here: a running window never restarts.
          if (d_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + c_one;
            if (r_cnt == c_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_avg       <= w_avg;
          r_avg_valid <= 1'b1;
          if (cont) begin
            r_state <= S_ACCUM;
            // A strobe in DONE is the first sample of the next window.
            if (d_valid) begin
              r_acc <= w_d_ext;
              r_cnt <= c_one;
            end else begin
              r_acc <= '0;
              r_cnt <= '0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign avg       = r_avg;
  assign avg_valid = r_avg_valid;
  assign busy      = (r_state != S_IDLE);
  assign cnt       = r_cnt;

`ifdef AVG_PEAK_EN
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_peak;

  // Running maximum follows exactly the same window boundaries as r_acc.
  always_ff @(posedge carry or negedge rst) begin
    if (!rst) begin
      r_max  <= '0;
      r_peak <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_max <= '0;
          end
        end
        S_ACCUM: begin
          if (d_valid && (D > r_max)) begin
            r_max <= D;
          end
        end
        S_DONE: begin
          r_peak <= r_max;
          if (cont && d_valid) begin
            r_max <= D;
          end else begin
            r_max <= '0;
          end
        end
        default: begin
          r_max <= '0;
        end
      endcase
    end
  end

  assign peak = r_peak;
`else
  assign peak = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_window_averager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_window_averager
//  Purpose  : Self-checking bench for d_window_averager (LOG2_N=3, DW=5).
//             Directed scenarios followed by random traffic; every cycle the
//             outputs are compared with a queue-based window model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d_window_averager;

  localparam int LOG2_N = 3;
  localparam int DW     = 5;
  localparam int N      = 1 << LOG2_N;

  logic              carry;
  logic              rst;
  logic [DW-1:0]     D;
  logic              d_valid;
  logic              start;
  logic              cont;
  logic [DW-1:0]     avg;
  logic              avg_valid;
  logic              busy;
  logic [LOG2_N:0]   cnt;
  logic [DW-1:0]     peak;

  d_window_averager #(.LOG2_N(LOG2_N), .DW(DW)) dut (
    .carry     (carry),
    .rst       (rst),
    .D         (D),
    .d_valid   (d_valid),
    .start     (start),
    .cont      (cont),
    .avg       (avg),
    .avg_valid (avg_valid),
    .busy      (busy),
    .cnt       (cnt),
    .peak      (peak)
  );

  initial carry = 1'b0;
  always #5 carry = ~carry;

  int total = 0;
  int bad   = 0;

  // Reference model: the current window is just a queue of accepted samples.
  int q[$];
  bit m_open;      // a window is open and collecting
  bit m_full;      // N samples held, result due on the next edge
  int e_avg;
  int e_peak;
  bit e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_open  = 1'b0;
    m_full  = 1'b0;
    e_avg   = 0;
    e_peak  = 0;
    e_valid = 1'b0;
  endtask

  // Advances the model by one clock for the given inputs.
  task automatic model_step(input bit s, input bit c, input bit dv, input int d);
    int sum;
    int mx;
    e_valid = 1'b0;
    if (m_full) begin
      sum = 0;
      mx  = 0;
      foreach (q[i]) begin
        sum += q[i];
        if (q[i] > mx) mx = q[i];
      end
      e_avg   = (sum + N / 2) / N;
`ifdef AVG_PEAK_EN
      e_peak  = mx;
`else
      e_peak  = 0;
`endif
      e_valid = 1'b1;
      m_full  = 1'b0;
      q.delete();
      m_open  = c;
      if (c && dv) q.push_back(d);
    end else if (m_open) begin
      if (dv) q.push_back(d);
      if (q.size() == N) m_full = 1'b1;
    end else if (s) begin
      m_open = 1'b1;
      q.delete();
    end
  endtask

  task automatic check_all();
    chk("avg_valid", 32'(avg_valid), 32'(e_valid));
    chk("avg", 32'(avg), 32'(e_avg));
    chk("peak", 32'(peak), 32'(e_peak));
    chk("busy", 32'(busy), 32'(m_open || m_full));
    if (m_open || m_full) chk("cnt", 32'(cnt), 32'(q.size()));
  endtask

  task automatic step(input bit s, input bit c, input bit dv, input int d);
    logic [31:0] dd;
    dd      = 32'(d);
    start   = s;
    cont    = c;
    d_valid = dv;
    D       = dd[DW-1:0];
    model_step(s, c, dv, d);
    @(posedge carry);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear without a clock.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    model_reset();
    chk("rst_avg", 32'(avg), 32'd0);
    chk("rst_avg_valid", 32'(avg_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    start   = 1'b0;
    d_valid = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int x;
    rst = 1'b0; start = 1'b0; cont = 1'b0; d_valid = 1'b0; D = '0;
    model_reset();
    repeat (2) @(posedge carry);
    #1;
    chk("init_avg", 32'(avg), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_cnt", 32'(cnt), 32'd0);
    chk("init_peak", 32'(peak), 32'd0);
    rst = 1'b1;

    // strobes before any start must be ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 9);

    // Test 1: constant 13
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 13);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t1_avg", 32'(avg), 32'd13);
    chk("t1_valid", 32'(avg_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t1_pulse_end", 32'(avg_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Test 2: ramp 0..7
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, i);
    step(1'b0, 1'b0, 1'b1, 30);  // DONE strobe with cont=0 is dropped
    chk("t2_avg", 32'(avg), 32'd4);
    step(1'b0, 1'b0, 1'b0, 0);

    // Test 3: full scale then zero
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 31);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t3_max", 32'(avg), 32'd31);
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t3_zero", 32'(avg), 32'd0);

    // Test 4: continuous windows, alternating 10/11, then cont dropped mid-window
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4 * N; i++) begin
      step(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 10 : 11);
      if (avg_valid) chk("t4_avg", 32'(avg), 32'd11);
    end
    for (int i = 0; i < 2 * N; i++) step(1'b0, (i < 2), 1'b1, (i % 2 == 0) ? 10 : 11);
    step(1'b0, 1'b0, 1'b0, 0);

    // Test 5: reset after 5 samples, then a clean window of 20
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 25);
    pulse_reset();
    step(1'b0, 1'b1, 1'b1, 7);  // cont alone does not open a window
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 20);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("t5_avg", 32'(avg), 32'd20);

    // Test 6: start re-pulsed at cnt=3
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) step((i == 3), 1'b0, 1'b1, 2 + 3 * i);
    step(1'b1, 1'b0, 1'b0, 0);  // start in DONE is ignored too
    chk("t6_avg", 32'(avg), 32'd13);  // (2+5+..+23 = 100, +4) >> 3
    step(1'b0, 1'b0, 1'b0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      x = int'($urandom_range(0, 199));
      if (x == 0) begin
        pulse_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
